// File: rtl/flow_pkg.sv
// -----------------------------------------------------------------------------
// flow_pkg
// Shared constants for the OpenFlow lookup responder: key width, key field
// boundaries and the default table geometry.
// Key layout (MSB first): ingress port[115:112], eth_src[111:64],
//                         ipv4_src[63:32], ipv4_dst[31:0]
// -----------------------------------------------------------------------------
package flow_pkg;

   localparam int KEY_W      = 116;

   // Most-significant bit of each key field
   localparam int INPORT_MSB = 115;
   localparam int ETHSRC_MSB = 111;
   localparam int IPSRC_MSB  = 63;
   localparam int IPDST_MSB  = 31;

   localparam int DEF_NPORT  = 4;
   localparam int DEF_NENTRY = 8;

endpackage

// File: rtl/flow_entry_match.sv
// -----------------------------------------------------------------------------
// flow_entry_match
// Storage for one flow table entry (valid, key, care mask, port bitmap) plus a
// combinational masked compare against the current lookup key.
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset (clears valid only)
//   i_wr_en       in   write this entry
//   i_wr_valid    in   new valid bit (0 deletes the entry)
//   i_wr_key      in   new match key
//   i_wr_mask     in   new care mask, 1 = bit compared
//   i_wr_port     in   new forwarding bitmap
//   i_lookup_key  in   key being looked up
//   o_hit         out  entry valid and key matches under mask
//   o_port        out  stored forwarding bitmap
// -----------------------------------------------------------------------------
module flow_entry_match
   import flow_pkg::*;
#(
   parameter int KEY_W = flow_pkg::KEY_W,
   parameter int NPORT = DEF_NPORT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic             i_wr_valid,
   input  logic [KEY_W-1:0] i_wr_key,
   input  logic [KEY_W-1:0] i_wr_mask,
   input  logic [NPORT-1:0] i_wr_port,
   input  logic [KEY_W-1:0] i_lookup_key,
   output logic             o_hit,
   output logic [NPORT-1:0] o_port
);

   logic             r_valid;
   logic [KEY_W-1:0] r_key;
   logic [KEY_W-1:0] r_mask;
   logic [NPORT-1:0] r_port;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (i_wr_en) begin
         r_valid <= i_wr_valid;
      end
   end

   // Key, mask and port carry no reset; the valid bit alone gates a hit.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_key  <= i_wr_key;
         r_mask <= i_wr_mask;
         r_port <= i_wr_port;
      end
   end

   // An all-zero mask turns a valid entry into a wildcard.
   assign o_hit  = r_valid && (((i_lookup_key ^ r_key) & r_mask) == '0);
   assign o_port = r_port;

endmodule

// File: rtl/flow_lookup.sv
// -----------------------------------------------------------------------------
// flow_lookup
// Responder for the forwarder's OpenFlow lookup interface. Every request is
// answered exactly two cycles later with an ack, plus the port bitmap of the
// lowest-index matching entry, or err on a miss. Hit/miss counters saturate.
//
// Ports:
//   sys_clk             in   clock
//   sys_rst_n           in   synchronous active-low reset
//   of_lookup_req       in   one-cycle lookup strobe
//   of_lookup_data      in   lookup key (valid with req)
//   of_lookup_ack       out  one-cycle response strobe
//   of_lookup_err       out  miss indicator, valid with ack
//   of_lookup_fwd_port  out  port bitmap, valid with ack, held otherwise
//   tbl_wr_en           in   table write strobe
//   tbl_wr_addr         in   entry index
//   tbl_wr_valid        in   entry valid bit (0 deletes)
//   tbl_wr_key          in   match key
//   tbl_wr_mask         in   care mask, 1 = bit compared
//   tbl_wr_port         in   forwarding bitmap
//   stat_clr            in   clear both counters (wins over increment)
//   stat_hit            out  saturating hit count
//   stat_miss           out  saturating miss count
// -----------------------------------------------------------------------------
module flow_lookup
   import flow_pkg::*;
#(
   parameter int NPORT  = DEF_NPORT,
   parameter int NENTRY = DEF_NENTRY,
   parameter int KEY_W  = flow_pkg::KEY_W,
   parameter int AW     = 3
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             of_lookup_req,
   input  logic [KEY_W-1:0] of_lookup_data,
   output logic             of_lookup_ack,
   output logic             of_lookup_err,
   output logic [NPORT-1:0] of_lookup_fwd_port,
   input  logic             tbl_wr_en,
   input  logic [AW-1:0]    tbl_wr_addr,
   input  logic             tbl_wr_valid,
   input  logic [KEY_W-1:0] tbl_wr_key,
   input  logic [KEY_W-1:0] tbl_wr_mask,
   input  logic [NPORT-1:0] tbl_wr_port,
   input  logic             stat_clr,
   output logic [31:0]      stat_hit,
   output logic [31:0]      stat_miss
);

   logic [NENTRY-1:0] w_wr_sel;
   logic [NENTRY-1:0] w_hit;
   logic [NPORT-1:0]  w_port [NENTRY];

   // ---------------------------------------------------------------- table
   genvar gi;
   generate
      for (gi = 0; gi < NENTRY; gi++) begin : g_entry
         // Addresses at or above NENTRY select no entry and are dropped.
         assign w_wr_sel[gi] = tbl_wr_en && (tbl_wr_addr == AW'(gi));

         flow_entry_match #(
            .KEY_W (KEY_W),
            .NPORT (NPORT)
         ) u_entry (
            .clk          (sys_clk),
            .rst_n        (sys_rst_n),
            .i_wr_en      (w_wr_sel[gi]),
            .i_wr_valid   (tbl_wr_valid),
            .i_wr_key     (tbl_wr_key),
            .i_wr_mask    (tbl_wr_mask),
            .i_wr_port    (tbl_wr_port),
            .i_lookup_key (of_lookup_data),
            .o_hit        (w_hit[gi]),
            .o_port       (w_port[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------------- stage 1
   logic              r_req_d1;
   logic [NENTRY-1:0] r_hit_vec;
   logic [NPORT-1:0]  r_port_snap [NENTRY];

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_req_d1  <= 1'b0;
         r_hit_vec <= '0;
      end else begin
         r_req_d1  <= of_lookup_req;
         r_hit_vec <= w_hit;
      end
   end

   // Port bitmaps are captured alongside the hit vector so that a write
   // landing while the lookup is in stage 2 cannot change its answer: the
   // whole response reflects the table as it was when the req was sampled.
   always_ff @(posedge sys_clk) begin
      for (int e = 0; e < NENTRY; e++) begin
         r_port_snap[e] <= w_port[e];
      end
   end

   // -------------------------------------------------------------- stage 2
   logic             w_any_hit;
   logic [NPORT-1:0] w_sel_port;

   // Scan downwards so the lowest-index hit is the last assignment.
   always_comb begin
      w_any_hit  = 1'b0;
      w_sel_port = '0;
      for (int e = NENTRY - 1; e >= 0; e--) begin
         if (r_hit_vec[e]) begin
            w_any_hit  = 1'b1;
            w_sel_port = r_port_snap[e];
         end
      end
   end

   logic             r_ack;
   logic             r_err;
   logic [NPORT-1:0] r_fwd_port;
   logic [31:0]      r_hit_cnt;
   logic [31:0]      r_miss_cnt;

   // Counters step on the same edge that registers the ack, so they already
   // include a response in the cycle it is presented.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_fwd_port <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_ack <= r_req_d1;
         r_err <= r_req_d1 && !w_any_hit;
         if (r_req_d1) begin
            r_fwd_port <= w_any_hit ? w_sel_port : '0;
         end

         if (stat_clr) begin
            r_hit_cnt <= '0;
         end else if (r_req_d1 && w_any_hit && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end

         if (stat_clr) begin
            r_miss_cnt <= '0;
         end else if (r_req_d1 && !w_any_hit && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign of_lookup_ack      = r_ack;
   assign of_lookup_err      = r_err;
   assign of_lookup_fwd_port = r_fwd_port;
   assign stat_hit           = r_hit_cnt;
   assign stat_miss          = r_miss_cnt;

endmodule

// File: doc/flow_lookup.md
Name: flow_lookup

Overview:
Responder side of the forwarder's OpenFlow lookup interface. It holds a small flow table of masked 116-bit keys, each with a forwarding port bitmap. It answers every of_lookup_req with a fixed-latency ack carrying the matched port bitmap, or err on miss. The table is written by the management/NIC side through a simple write port; hit and miss statistics counters are exported.

Parameters:
NPORT, 4, width of forwarding port bitmap (bit i = port i)
NENTRY, 8, number of flow table entries (power of 2, 2..16)
KEY_W, 116, lookup key width: ingress port[115:112], eth_src[111:64], ipv4_src[63:32], ipv4_dst[31:0]
AW, 3, entry address width, equal to log2(NENTRY)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; synchronous, active-low
of_lookup_req  in  1  one-cycle lookup request strobe
of_lookup_data  in  KEY_W  key, valid in the req cycle
of_lookup_ack  out  1  one-cycle response strobe
of_lookup_err  out  1  miss indicator, valid with ack
of_lookup_fwd_port  out  NPORT  port bitmap, valid with ack
tbl_wr_en  in  1  table write strobe
tbl_wr_addr  in  AW  entry index
tbl_wr_valid  in  1  entry valid bit; 0 deletes the entry
tbl_wr_key  in  KEY_W  match key
tbl_wr_mask  in  KEY_W  care mask; 1 = bit compared
tbl_wr_port  in  NPORT  forwarding bitmap of the entry
stat_clr  in  1  clears both counters
stat_hit  out  32  number of hits
stat_miss  out  32  number of misses

Behaviour:
- Reset (sys_rst_n low at a clock edge): all entry valid bits clear. Key, mask and port storage need not reset. All outputs go to 0. Any in-flight lookup is discarded, so no ack issues for a req sampled during or before the reset cycle.
- Match rule: entry e hits when valid[e] and ((key ^ tbl_key[e]) & tbl_mask[e]) == 0. An all-zero mask with valid=1 is a wildcard entry and hits everything.
- Pipeline, fixed latency 2, fully pipelined. One req per cycle is accepted with no backpressure.
  - Stage 1 (req sampled at edge T): register the NENTRY-bit hit vector and a req_d1 flag.
  - Stage 2 (edge T+1): priority-select the lowest-index hit. Register ack, err and fwd_port.
  - Outputs are valid in the cycle following edge T+1, i.e. two cycles after req.
- Hit: ack=1, err=0, fwd_port = tbl_port[lowest hit].
- Miss (no hit): ack=1, err=1, fwd_port = 0 (drop).
- ack and err are single-cycle pulses. fwd_port holds its last value between acks; err returns to 0 when ack is 0.
- Write/lookup collision: a write at edge T updates storage at T. A req sampled at the same edge T compares against the pre-write contents. A req at edge T+1 or later sees the new entry.
- Two writes to the same address in consecutive cycles: the last one wins.
- tbl_wr_addr >= NENTRY: cannot occur when NENTRY = 2^AW. Out-of-range addresses are ignored.
- Counters: stat_hit increments on each ack with err=0; stat_miss increments on each ack with err=1.
  - Both counters saturate at 0xFFFFFFFF and do not wrap.
  - stat_clr has priority over an increment in the same cycle; the result is 0.
- The forwarder requires its ack within 4 cycles of req; the fixed 2-cycle latency satisfies this.

Decomposition:
- Shared package (flow_pkg): KEY_W and field offset constants (INPORT_MSB=115, ETHSRC_MSB=111, IPSRC_MSB=63, IPDST_MSB=31), plus the default NPORT and NENTRY.
- One sub-module, flow_entry_match: a single entry's storage (valid, key, mask, port) with a combinational masked compare output. It is instantiated NENTRY times in a generate loop.
- The priority encoder, pipeline registers and counters live in the top level.

Test Plan:
- Empty table after reset: req with key 0x0_AABBCCDDEEFF_0A000001_0A000002 -> ack and err exactly 2 cycles later, fwd_port=0, stat_miss=1.
- Exact match: write entry 3 with that key, mask all-ones, port 4'b0100 -> the same req returns ack, err=0, fwd_port=4'b0100; stat_hit=1.
- Priority plus wildcard: entry 0 masked only on ipv4_dst=0x0A000002 with port 4'b0001; entry 3 as above -> fwd_port=4'b0001. After deleting entry 0 (tbl_wr_valid=0) -> fwd_port=4'b0100.
- Back-to-back: reqs on 4 consecutive cycles alternating hit key and miss key -> 4 consecutive acks with err pattern 0,1,0,1 and counters hit=2, miss=2.
- Collision: write entry 5 (port 4'b1000, a new key) at the same edge as a req for that key -> miss. A req one cycle later -> hit, 4'b1000.
- Reset mid-flight: assert sys_rst_n=0 in the cycle after a req -> no ack ever appears, counters are 0, and a subsequent lookup misses.
